xmem_arbiter: RTL and testbench
===============================

Name: xmem_arbiter

Overview:
- Two-master Wishbone (classic, big-endian bit numbering) arbiter that shares the single external-memory (HyperRAM) slave port.
- Master 0 is the service processor xmem port; master 1 is a second requester (e.g. tape/overlay DMA).
- Round-robin grant, locked for the whole cyc tenure; per-access watchdog aborts hung transfers with an error.
- Sits between the requesters and hyperram_wrapper in the top level.

Parameters:
- TIMEOUT, 1024, cycles a granted strobe may wait for slave ack before abort (≥2).
- TO_BITS, 11, width of the watchdog counter; must satisfy 2^TO_BITS > TIMEOUT.

Ports:
- clk  in  1  system clock (108 MHz domain)
- reset_n  in  1  asynchronous, active-low reset
- m0_adr_i, m1_adr_i  in  [2:31]  master word address
- m0_dat_i, m1_dat_i  in  [0:31]  master write data
- m0_dat_o, m1_dat_o  out  [0:31]  read data to master
- m0_we_i, m1_we_i  in  1  write enable
- m0_sel_i, m1_sel_i  in  [0:3]  byte selects
- m0_stb_i, m1_stb_i  in  1  strobe
- m0_cyc_i, m1_cyc_i  in  1  cycle / bus request
- m0_ack_o, m1_ack_o  out  1  ack
- m0_err_o, m1_err_o  out  1  timeout error (one-cycle pulse)
- s_adr_o  out  [2:31]; s_dat_o  out  [0:31]; s_dat_i  in  [0:31]; s_we_o  out  1; s_sel_o  out  [0:3]; s_stb_o  out  1; s_cyc_o  out  1; s_ack_i  in  1  slave side
- grant  out  [0:1]  one-hot current owner (debug/LED)
- timeout_count  out  [0:7]  saturating count of aborts (debug)

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous and active-low. Under reset: state=IDLE, grant=00, last=1 (so master 0 wins the first tie), watchdog=0, timeout_count=0. All ack/err/stb/cyc outputs are 0.
- States: IDLE, OWN0, OWN1, ABORT (ABORT records which owner was aborted).
- IDLE:
  - Only m0_cyc_i → OWN0. Only m1_cyc_i → OWN1.
  - Both → the master != last wins. last updates on every grant.
  - Grant is registered: 1 cycle of arbitration latency from cyc assertion to s_cyc_o.
- OWNx:
  - s_adr/dat/we/sel come from master x combinationally.
  - s_cyc_o = mx_cyc_i. s_stb_o = mx_cyc_i & mx_stb_i.
  - mx_ack_o = s_ack_i. The other master's ack/err stay 0.
  - Both m0_dat_o and m1_dat_o = s_dat_i (data is qualified by ack).
  - Leaves to IDLE on the cycle after mx_cyc_i deasserts. No new grant is issued in that same cycle, so there is at least 1 idle cycle between tenures.
  - Grant is never preempted while cyc is held. Multiple stb/ack pairs are allowed within one tenure.
- Watchdog:
  - Counts while in OWNx with s_stb_o=1 and s_ack_i=0. Clears on s_ack_i or when stb is low.
  - When the count reaches TIMEOUT-1 without ack: mx_err_o=1 for exactly one cycle, go to ABORT, timeout_count += 1 (saturates at 255).
  - In ABORT: s_cyc_o=s_stb_o=0, late s_ack_i is discarded (not forwarded). Return to IDLE once the aborted master's cyc is low.
- Ack and timeout in the same cycle: ack wins, no err.
- Owner drops cyc while the other master requests: other is granted on the cycle after IDLE is entered. Round-robin guarantees alternation under continuous contention.
- Reset asserted mid-tenure: outputs drop to 0 immediately (async); the in-flight transfer is lost and the slave must tolerate cyc going low.
- Master dropping stb while keeping cyc: legal; the watchdog clears.

Decomposition:
- Shared package xmem_arb_pkg: state encodings (ARB_IDLE, ARB_OWN0, ARB_OWN1, ARB_ABORT), Wishbone width constants (XMEM_ADR_LO=2, XMEM_DAT_W=32, XMEM_SEL_W=4).
- One natural sub-module: xmem_arb_watchdog (counter plus compare, with inputs run/clear and output expire), parameterised by TIMEOUT and TO_BITS.

Test Plan:
- Single master: m0 cyc+stb read at adr 0x0000100, slave acks after 5 cycles with 0xDEADBEEF → s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o and m0_dat_o=0xDEADBEEF, m1_ack_o stays 0, grant=10.
- Simultaneous request after reset: both cyc in the same cycle → m0 granted first. After m0 drops cyc, m1 is granted after exactly 1 IDLE cycle. Repeat with both held continuously → grants alternate 0,1,0,1.
- Locked tenure: m1 performs 4 stb/ack writes with sel=1100 under one cyc while m0 requests throughout → m0 is not granted until 1 cycle after m1_cyc_i falls, and all 4 writes appear on the s_ port with sel=1100.
- Timeout: TIMEOUT=16, slave never acks m0 → m0_err_o pulses once on the 16th wait cycle, s_cyc_o=0 from the next cycle, timeout_count=1, and a late s_ack_i is not seen on m0_ack_o.
- Ack/timeout race: slave acks exactly on cycle TIMEOUT-1 → ack delivered, no err, timeout_count unchanged.
- Reset mid-transfer: pull reset_n low while in OWN1 with stb high → s_cyc_o, s_stb_o and grant go to 0 without a clock edge. After release, a fresh m1 request is granted normally.

Source files
------------

// File: rtl/xmem_arb_pkg.sv
// Shared definitions for the external-memory (HyperRAM) Wishbone arbiter.
// Holds the arbiter state encoding and the Wishbone bus widths so the top
// level and any future users agree on one set of numbers.
//   ARB_IDLE  : no owner, arbitration happens here
//   ARB_OWN0  : master 0 (service processor) owns the slave port
//   ARB_OWN1  : master 1 (DMA requester) owns the slave port
//   ARB_ABORT : watchdog fired, waiting for the aborted master to drop cyc
package xmem_arb_pkg;

  localparam int XMEM_ADR_LO = 2;
  localparam int XMEM_DAT_W  = 32;
  localparam int XMEM_SEL_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_ABORT = 2'd3
  } arb_state_e;

endpackage

// File: rtl/xmem_arb_watchdog.sv
// Per-access watchdog for the xmem arbiter.
// Counts cycles while a granted strobe waits for the slave ack and raises
// expire_o on the cycle in which the count has reached TIMEOUT-1.
//   clk, reset_n : clock and asynchronous active-low reset
//   run_i        : a granted strobe is waiting on the slave this cycle
//   clear_i      : restart the count (ack seen, strobe low, or no owner)
//   expire_o     : the waiting access has used up its budget this cycle
module xmem_arb_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_BITS = 11
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [TO_BITS-1:0] LIMIT = TO_BITS'(TIMEOUT - 1);

  logic [TO_BITS-1:0] count_q;
  logic [TO_BITS-1:0] count_d;

  // Expiry is combinational so the error pulse lands in the same cycle the
  // budget runs out; an ack in that cycle drops run_i and suppresses it.
  assign expire_o = run_i && (count_q == LIMIT);

  // Restart after an expiry as well, so the counter never wraps while the
  // arbiter is moving into its abort state.
  always_comb begin
    count_d = count_q;
    if (clear_i || expire_o) begin
      count_d = '0;
    end else if (run_i) begin
      count_d = count_q + TO_BITS'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/xmem_arbiter.sv
// Two-master Wishbone classic arbiter in front of the HyperRAM slave port.
// Master 0 is the service processor xmem port, master 1 a second requester.
// Grants are round-robin, registered (one cycle of latency) and locked for
// the whole cyc tenure; a watchdog aborts accesses the slave never acks.
//   clk, reset_n    : clock and asynchronous active-low reset
//   m0_* / m1_*     : Wishbone master-side ports (adr, dat, we, sel, stb,
//                     cyc in; dat, ack, err out)
//   s_*             : Wishbone slave-side port towards hyperram_wrapper
//   grant           : one-hot current owner, bit 0 = master 0
//   timeout_count   : saturating number of watchdog aborts
module xmem_arbiter
  import xmem_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int TO_BITS = 11
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [XMEM_ADR_LO:XMEM_DAT_W-1] m0_adr_i,
  input  logic [0:XMEM_DAT_W-1]           m0_dat_i,
  output logic [0:XMEM_DAT_W-1]           m0_dat_o,
  input  logic                            m0_we_i,
  input  logic [0:XMEM_SEL_W-1]           m0_sel_i,
  input  logic                            m0_stb_i,
  input  logic                            m0_cyc_i,
  output logic                            m0_ack_o,
  output logic                            m0_err_o,
  input  logic [XMEM_ADR_LO:XMEM_DAT_W-1] m1_adr_i,
  input  logic [0:XMEM_DAT_W-1]           m1_dat_i,
  output logic [0:XMEM_DAT_W-1]           m1_dat_o,
  input  logic                            m1_we_i,
  input  logic [0:XMEM_SEL_W-1]           m1_sel_i,
  input  logic                            m1_stb_i,
  input  logic                            m1_cyc_i,
  output logic                            m1_ack_o,
  output logic                            m1_err_o,
  output logic [XMEM_ADR_LO:XMEM_DAT_W-1] s_adr_o,
  output logic [0:XMEM_DAT_W-1]           s_dat_o,
  input  logic [0:XMEM_DAT_W-1]           s_dat_i,
  output logic                            s_we_o,
  output logic [0:XMEM_SEL_W-1]           s_sel_o,
  output logic                            s_stb_o,
  output logic                            s_cyc_o,
  input  logic                            s_ack_i,
  output logic [0:1]                      grant,
  output logic [0:7]                      timeout_count
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       abortOwner_q, abortOwner_d;
  logic [0:7] timeoutCount_q, timeoutCount_d;

  logic ownStb;
  logic wdRun;
  logic wdClear;
  logic wdExpire;

  // The granted strobe is derived straight from the owner's inputs rather
  // than from s_stb_o so the watchdog path stays free of combinational loops.
  assign ownStb  = ((state_q == ARB_OWN0) && m0_cyc_i && m0_stb_i) ||
                   ((state_q == ARB_OWN1) && m1_cyc_i && m1_stb_i);
  assign wdRun   = ownStb && !s_ack_i;
  assign wdClear = !wdRun;

  xmem_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .run_i    (wdRun),
    .clear_i  (wdClear),
    .expire_o (wdExpire)
  );

  // Errors only ever reach the master that owns the bus when time runs out.
  assign m0_err_o      = (state_q == ARB_OWN0) && wdExpire;
  assign m1_err_o      = (state_q == ARB_OWN1) && wdExpire;
  assign timeout_count = timeoutCount_q;

  // State register; last starts at 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARB_IDLE;
      last_q         <= 1'b1;
      abortOwner_q   <= 1'b0;
      timeoutCount_q <= '0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      abortOwner_q   <= abortOwner_d;
      timeoutCount_q <= timeoutCount_d;
    end
  end

  // Next-state logic: arbitration only happens in IDLE, so every tenure is
  // followed by at least one idle cycle and an owner is never preempted.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    abortOwner_d   = abortOwner_q;
    timeoutCount_d = timeoutCount_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = ARB_OWN0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ARB_OWN1;
          last_d  = 1'b1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (wdExpire) begin
          state_d      = ARB_ABORT;
          abortOwner_d = (state_q == ARB_OWN1);
          if (timeoutCount_q != 8'hFF) begin
            timeoutCount_d = timeoutCount_q + 8'd1;
          end
        end else if ((state_q == ARB_OWN0) ? !m0_cyc_i : !m1_cyc_i) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ABORT: begin
        if (abortOwner_q ? !m1_cyc_i : !m0_cyc_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output logic: the owner is muxed onto the slave port combinationally;
  // in IDLE and ABORT the slave port is quiet and late acks are dropped.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    grant    = 2'b00;
    case (state_q)
      ARB_OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i && m0_stb_i;
        m0_ack_o = s_ack_i;
        grant    = 2'b10;
      end
      ARB_OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i && m1_stb_i;
        m1_ack_o = s_ack_i;
        grant    = 2'b01;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_xmem_arbiter.sv
// Directed self-checking bench for xmem_arbiter (TIMEOUT=16).
// Inputs change 1 ns after the rising edge and outputs are sampled 1 ns
// later, well clear of the next active edge.
module tb_xmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:31] m0_adr_i = '0, m1_adr_i = '0;
  logic [0:31] m0_dat_i = '0, m1_dat_i = '0;
  logic [0:31] m0_dat_o, m1_dat_o;
  logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
  logic [0:3]  m0_sel_i = '0, m1_sel_i = '0;
  logic        m0_stb_i = 1'b0, m1_stb_i = 1'b0;
  logic        m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [2:31] s_adr_o;
  logic [0:31] s_dat_o;
  logic [0:31] s_dat_i = '0;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [0:3]  s_sel_o;
  logic        s_ack_i = 1'b0;
  logic [0:1]  grant;
  logic [0:7]  timeout_count;

  int checks = 0;
  int failures = 0;

  xmem_arbiter #(.TIMEOUT(16), .TO_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i),
    .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
    .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
    .grant(grant), .timeout_count(timeout_count)
  );

  // 100 MHz-ish free-running clock.
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request/ack controls of both masters and the slave, then let
  // combinational outputs settle before any checks.
  task automatic applyStimulus(input logic c0, input logic s0, input logic c1,
                               input logic s1, input logic ack);
    m0_cyc_i = c0;
    m0_stb_i = s0;
    m1_cyc_i = c1;
    m1_stb_i = s1;
    s_ack_i  = ack;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    $display("[TB] starting xmem_arbiter directed test");

    // Reset state.
    doReset();
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    checkOutput("rst_s_stb", 32'(s_stb_o), 32'h0);
    checkOutput("rst_tocount", 32'(timeout_count), 32'h0);
    checkOutput("rst_m0_ack", 32'(m0_ack_o), 32'h0);

    // Single master read with ack after 5 wait cycles.
    m0_adr_i = 30'h0000100;
    m0_sel_i = 4'b1111;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("single_latency_cyc", 32'(s_cyc_o), 32'h0);
    tick();
    checkOutput("single_s_cyc", 32'(s_cyc_o), 32'h1);
    checkOutput("single_grant", 32'(grant), 32'h2);
    checkOutput("single_s_adr", 32'(s_adr_o), 32'h100);
    checkOutput("single_no_ack_yet", 32'(m0_ack_o), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    tick();
    s_dat_i = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("single_m0_ack", 32'(m0_ack_o), 32'h1);
    checkOutput("single_m0_dat", 32'(m0_dat_o), 32'hDEADBEEF);
    checkOutput("single_m1_ack", 32'(m1_ack_o), 32'h0);
    checkOutput("single_m0_err", 32'(m0_err_o), 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("single_drop_s_cyc", 32'(s_cyc_o), 32'h0);
    tick();
    checkOutput("single_idle_grant", 32'(grant), 32'h0);

    // Simultaneous request straight after reset: master 0 first.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("tie_first_grant", 32'(grant), 32'h2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("tie_m0_ack", 32'(m0_ack_o), 32'h1);
    checkOutput("tie_m1_ack", 32'(m1_ack_o), 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("tie_idle_gap", 32'(grant), 32'h0);
    tick();
    checkOutput("tie_second_grant", 32'(grant), 32'h1);
    checkOutput("tie_second_s_cyc", 32'(s_cyc_o), 32'h1);

    // Continuous contention: each owner releases and re-requests at once.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rr_idle1", 32'(grant), 32'h0);
    tick();
    checkOutput("rr_grant_m0", 32'(grant), 32'h2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rr_idle2", 32'(grant), 32'h0);
    tick();
    checkOutput("rr_grant_m1", 32'(grant), 32'h1);

    // Locked tenure: four writes by master 1 while master 0 waits.
    doReset();
    m1_we_i  = 1'b1;
    m1_sel_i = 4'b1100;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("lock_grant_m1", 32'(grant), 32'h1);
    for (int i = 0; i < 4; i++) begin
      m1_adr_i = 30'(32'h200 + i);
      m1_dat_i = 32'hA5A50000 + 32'(i);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("lock_grant_held", 32'(grant), 32'h1);
      checkOutput("lock_s_sel", 32'(s_sel_o), 32'hC);
      checkOutput("lock_s_we", 32'(s_we_o), 32'h1);
      checkOutput("lock_s_adr", 32'(s_adr_o), 32'h200 + 32'(i));
      checkOutput("lock_s_dat", 32'(s_dat_o), 32'hA5A50000 + 32'(i));
      checkOutput("lock_m1_ack", 32'(m1_ack_o), 32'h1);
      checkOutput("lock_m0_ack", 32'(m0_ack_o), 32'h0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lock_release_cycle", 32'(grant), 32'h1);
    tick();
    checkOutput("lock_idle_gap", 32'(grant), 32'h0);
    tick();
    checkOutput("lock_m0_granted", 32'(grant), 32'h2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Timeout: slave never acks master 0.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int w = 1; w <= 15; w++) begin
      checkOutput("to_no_err_early", 32'(m0_err_o), 32'h0);
      tick();
    end
    checkOutput("to_err_pulse", 32'(m0_err_o), 32'h1);
    checkOutput("to_m1_err", 32'(m1_err_o), 32'h0);
    checkOutput("to_s_cyc_at_err", 32'(s_cyc_o), 32'h1);
    tick();
    checkOutput("to_err_one_cycle", 32'(m0_err_o), 32'h0);
    checkOutput("to_abort_s_cyc", 32'(s_cyc_o), 32'h0);
    checkOutput("to_abort_s_stb", 32'(s_stb_o), 32'h0);
    checkOutput("to_count_one", 32'(timeout_count), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("to_late_ack_dropped", 32'(m0_ack_o), 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("to_back_idle", 32'(grant), 32'h0);

    // Ack exactly on the last watchdog cycle: ack wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int w = 1; w <= 15; w++) tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("race_ack", 32'(m0_ack_o), 32'h1);
    checkOutput("race_no_err", 32'(m0_err_o), 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("race_still_owned", 32'(s_cyc_o), 32'h1);
    checkOutput("race_grant", 32'(grant), 32'h2);
    checkOutput("race_count_same", 32'(timeout_count), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset pulled mid-tenure, then a fresh request.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("mid_grant_m1", 32'(grant), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    checkOutput("mid_rst_s_stb", 32'(s_stb_o), 32'h0);
    checkOutput("mid_rst_grant", 32'(grant), 32'h0);
    checkOutput("mid_rst_count", 32'(timeout_count), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("mid_regrant", 32'(grant), 32'h1);
    checkOutput("mid_regrant_s_cyc", 32'(s_cyc_o), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
